// File: rtl/instr_encoder_loader_if.sv
// Request/memory-write bundle for instr_encoder_loader: master = loader driver, slave = encoder.
// Handshakes: in_valid/in_ready for requests, mem_wr_en/mem_ready for memory writes.
interface instr_encoder_loader_if #(parameter int ADDR_W = 10);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_ready;

    modport master (
        output in_valid, op_sel, rs, rt, rd, shamt, imm, target, mem_ready,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  in_valid, op_sel, rs, rt, rd, shamt, imm, target, mem_ready,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes mnemonic+operand requests into 32-bit instruction words and streams them to program memory.
// Latency 1 (single output register); in_ready drops while full, clearing, or the held write is stalled.
// Optional ENC_CHECKSUM_EN adds a running XOR checksum of completed writes.
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    instr_encoder_loader_if.slave  bus,
    output logic [ADDR_W:0]        word_count,
    output logic                   full,
    output logic                   err_illegal,
    output logic                   err_range
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [31:0]            checksum
`endif
);
    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   CAP  = DEPTH[ADDR_W:0];

    logic              wr_en_q, wr_en_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ill_q, ill_d;
    logic              rng_q, rng_d;

    logic [31:0] enc_word;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic        is_shift, is_jr, is_branch, is_illegal, imm_oor;
    logic        accept, wr_done;

    assign is_shift   = (bus.op_sel >= 5'd7) && (bus.op_sel <= 5'd9);
    assign is_jr      = (bus.op_sel == 5'd11);
    assign is_branch  = (bus.op_sel >= 5'd24) && (bus.op_sel <= 5'd29);
    assign is_illegal = (bus.op_sel == 5'd31);
    // The 10-bit branch field fits only when imm[15:9] is a pure sign extension.
    assign imm_oor    = !((&bus.imm[15:9]) || !(|bus.imm[15:9]));

    always_comb begin
        funct    = 6'd0;
        opcode   = 6'd0;
        enc_word = 32'd0;
        if (bus.op_sel <= 5'd11) begin
            case (bus.op_sel)
                5'd0:    funct = 6'b100000;
                5'd1:    funct = 6'b100010;
                5'd2:    funct = 6'b100001;
                5'd3:    funct = 6'b100011;
                5'd4:    funct = 6'b100100;
                5'd5:    funct = 6'b100101;
                5'd6:    funct = 6'b100110;
                5'd7:    funct = 6'b000000;
                5'd8:    funct = 6'b000010;
                5'd9:    funct = 6'b000011;
                5'd10:   funct = 6'b101010;
                default: funct = 6'b001000;
            endcase
            enc_word = {6'b000000,
                        is_shift ? 5'd0 : bus.rs,
                        is_jr    ? 5'd0 : bus.rt,
                        is_jr    ? 5'd0 : bus.rd,
                        is_shift ? bus.shamt : 5'd0,
                        funct};
        end else if (bus.op_sel <= 5'd21) begin
            case (bus.op_sel)
                5'd12:   opcode = 6'b001000;
                5'd13:   opcode = 6'b001001;
                5'd14:   opcode = 6'b001100;
                5'd15:   opcode = 6'b001101;
                5'd16:   opcode = 6'b001110;
                5'd17:   opcode = 6'b001111;
                5'd18:   opcode = 6'b100011;
                5'd19:   opcode = 6'b101011;
                5'd20:   opcode = 6'b000100;
                default: opcode = 6'b000101;
            endcase
            enc_word = {opcode, (bus.op_sel == 5'd17) ? 5'd0 : bus.rs, bus.rt, bus.imm};
        end else if (bus.op_sel <= 5'd23) begin
            enc_word = {(bus.op_sel == 5'd22) ? 6'b000010 : 6'b000011, bus.target};
        end else begin
            case (bus.op_sel)
                5'd24:   funct = 6'b010001;
                5'd25:   funct = 6'b010010;
                5'd26:   funct = 6'b010011;
                5'd27:   funct = 6'b010100;
                5'd28:   funct = 6'b010101;
                5'd29:   funct = 6'b010110;
                default: funct = 6'b011000;
            endcase
            enc_word = {6'b011111, bus.rs, bus.rt,
                        (bus.op_sel == 5'd30) ? {bus.rd, 5'd0} : bus.imm[9:0],
                        funct};
        end
    end

    assign full         = (count_q == CAP);
    assign bus.in_ready = !clear && !full && (!wr_en_q || bus.mem_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign wr_done      = wr_en_q && bus.mem_ready;

`ifdef ENC_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    always_comb begin
        wr_en_d = wr_en_q;
        data_d  = data_q;
        addr_d  = addr_q;
        count_d = count_q;
        ill_d   = ill_q;
        rng_d   = rng_q;
`ifdef ENC_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (clear) begin
            wr_en_d = 1'b0;
            data_d  = 32'd0;
            addr_d  = BASE;
            count_d = '0;
            ill_d   = 1'b0;
            rng_d   = 1'b0;
`ifdef ENC_CHECKSUM_EN
            csum_d  = 32'd0;
`endif
        end else begin
            if (wr_done) begin
                addr_d  = addr_q + ADDR_W'(4);
                count_d = count_q + 1'b1;
                wr_en_d = 1'b0;
`ifdef ENC_CHECKSUM_EN
                csum_d  = csum_q ^ data_q;
`endif
            end
            // An accept implies the output register is free this cycle.
            if (accept) begin
                if (is_illegal) begin
                    ill_d = 1'b1;
                end else begin
                    wr_en_d = 1'b1;
                    data_d  = enc_word;
                    if (is_branch && imm_oor) rng_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q <= 1'b0;
            data_q  <= 32'd0;
            addr_q  <= BASE;
            count_q <= '0;
            ill_q   <= 1'b0;
            rng_q   <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            csum_q  <= 32'd0;
`endif
        end else begin
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            ill_q   <= ill_d;
            rng_q   <= rng_d;
`ifdef ENC_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_data = data_q;
    assign bus.mem_wr_addr = addr_q;
    assign word_count      = count_q;
    assign err_illegal     = ill_q;
    assign err_range       = rng_q;
`ifdef ENC_CHECKSUM_EN
    assign checksum        = csum_q;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomised and directed bench for instr_encoder_loader (DEPTH=4) against a behavioural model.
module tb_instr_encoder_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic [ADDR_W:0] word_count;
    logic full, err_illegal, err_range;
`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .word_count(word_count), .full(full),
        .err_illegal(err_illegal), .err_range(err_range)
`ifdef ENC_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state: one pending word plus counters and sticky flags.
    bit          m_pend;
    logic [31:0] m_data;
    int          m_addr, m_count;
    bit          m_ill, m_rng;

    task automatic model_reset();
        m_pend = 0; m_data = 0; m_addr = 0; m_count = 0; m_ill = 0; m_rng = 0;
    endtask

    function automatic logic [31:0] ref_enc(input int op, input int rs, input int rt, input int rd,
                                            input int sh, input int im, input int tg);
        int rf [0:11];
        int io [0:9];
        int cf [0:6];
        longint w;
        bit shf, jr;
        rf = '{32, 34, 33, 35, 36, 37, 38, 0, 2, 3, 42, 8};
        io = '{8, 9, 12, 13, 14, 15, 35, 43, 4, 5};
        cf = '{17, 18, 19, 20, 21, 22, 24};
        if (op < 12) begin
            shf = (op >= 7 && op <= 9);
            jr  = (op == 11);
            w = (shf ? 0 : rs) * 2**21 + (jr ? 0 : rt) * 2**16 + (jr ? 0 : rd) * 2**11
              + (shf ? sh : 0) * 64 + rf[op];
        end else if (op < 22) begin
            w = longint'(io[op-12]) * 2**26 + (op == 17 ? 0 : rs) * 2**21 + rt * 2**16 + im;
        end else if (op < 24) begin
            w = longint'(op == 22 ? 2 : 3) * 2**26 + tg;
        end else begin
            w = longint'(31) * 2**26 + rs * 2**21 + rt * 2**16 + cf[op-24]
              + ((op == 30) ? rd * 2**11 : (im % 1024) * 64);
        end
        return w[31:0];
    endfunction

    task automatic step(input bit v, input int op, input int a, input int b, input int c,
                        input int d, input logic [15:0] im, input logic [25:0] tg,
                        input bit mr, input bit cl);
        bit exp_rdy, fire, done;
        int sv;
        @(negedge clk);
        bus.in_valid = v; bus.op_sel = 5'(op); bus.rs = 5'(a); bus.rt = 5'(b);
        bus.rd = 5'(c); bus.shamt = 5'(d); bus.imm = im; bus.target = tg;
        bus.mem_ready = mr; clear = cl;
        #1;
        exp_rdy = !cl && (m_count != DEPTH) && (!m_pend || mr);
        check("in_ready", bus.in_ready, exp_rdy);
        check("mem_wr_en", bus.mem_wr_en, m_pend);
        check("mem_wr_addr", bus.mem_wr_addr, m_addr);
        check("mem_wr_data", bus.mem_wr_data, m_data);
        check("word_count", word_count, m_count);
        check("full", full, m_count == DEPTH);
        check("err_illegal", err_illegal, m_ill);
        check("err_range", err_range, m_rng);
        fire = v && exp_rdy;
        done = m_pend && mr;
        if (cl) begin
            model_reset();
        end else begin
            if (done) begin
                m_addr  = (m_addr + 4) % (2**ADDR_W);
                m_count = m_count + 1;
                m_pend  = 0;
            end
            if (fire) begin
                if (op == 31) m_ill = 1;
                else begin
                    m_pend = 1;
                    m_data = ref_enc(op, a, b, c, d, int'(im), int'(tg));
                    sv = int'($signed(im));
                    if (op >= 24 && op <= 29 && (sv < -512 || sv > 511)) m_rng = 1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input bit mr);
        step(0, 0, 0, 0, 0, 0, 16'd0, 26'd0, mr, 0);
    endtask

    task automatic do_clear();
        step(0, 0, 0, 0, 0, 0, 16'd0, 26'd0, 1, 1);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        bus.in_valid = 0; bus.op_sel = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0;
        bus.shamt = 0; bus.imm = 0; bus.target = 0; bus.mem_ready = 0;
        model_reset();
        #12;
        check("rst_wr_en", bus.mem_wr_en, 0);
        check("rst_data", bus.mem_wr_data, 0);
        check("rst_addr", bus.mem_wr_addr, 0);
        check("rst_count", word_count, 0);
        check("rst_flags", {full, err_illegal, err_range}, 0);
        @(negedge clk); rst_n = 1'b1;

        // add then drain
        step(1, 0, 1, 2, 3, 7, 16'd0, 26'd0, 1, 0);
        #1;
        check("add_data", bus.mem_wr_data, 32'h00221820);
        check("add_en", bus.mem_wr_en, 1);
        check("add_addr", bus.mem_wr_addr, 0);
        idle(1);
        #1;
        check("add_count", word_count, 1);
        do_clear();

        // lw then j back-to-back
        step(1, 18, 4, 5, 0, 0, 16'd8, 26'd0, 1, 0);
        #1;
        check("lw_data", bus.mem_wr_data, 32'h8C850008);
        check("lw_addr", bus.mem_wr_addr, 0);
        step(1, 22, 0, 0, 0, 0, 16'd0, 26'h10, 1, 0);
        #1;
        check("j_data", bus.mem_wr_data, 32'h08000010);
        check("j_addr", bus.mem_wr_addr, 4);
        idle(1);
        do_clear();

        // bgt in range then out of range
        step(1, 24, 1, 2, 0, 0, 16'hFFFF, 26'd0, 1, 0);
        #1;
        check("bgt_data", bus.mem_wr_data, 32'h7C22FFD1);
        check("bgt_rng0", err_range, 0);
        step(1, 24, 1, 2, 0, 0, 16'd600, 26'd0, 1, 0);
        #1;
        check("bgt600_data", bus.mem_wr_data, 32'h7C229611);
        check("bgt600_rng", err_range, 1);
        idle(1);
        #1;
        check("bgt600_count", word_count, 2);
        do_clear();

        // stall for three cycles, then release
        step(1, 5, 3, 4, 5, 0, 16'd0, 26'd0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 6, 7, 8, 9, 0, 16'd0, 26'd0, 0, 0);
        step(1, 6, 7, 8, 9, 0, 16'd0, 26'd0, 1, 0);
        idle(1);
        do_clear();

        // illegal code then clear
        step(1, 31, 1, 1, 1, 1, 16'd0, 26'd0, 1, 0);
        #1;
        check("ill_flag", err_illegal, 1);
        check("ill_no_wr", bus.mem_wr_en, 0);
        check("ill_count", word_count, 0);
        do_clear();
        #1;
        check("clr_ill", err_illegal, 0);
        check("clr_addr", bus.mem_wr_addr, 0);

        // fill to DEPTH, fifth stalls, async reset mid-stall
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, i, i + 1, i + 2, 0, 16'd0, 26'd0, 1, 0);
            idle(1);
        end
        #1;
        check("full_set", full, 1);
        step(1, 1, 1, 1, 1, 0, 16'd0, 26'd0, 1, 0);
        step(1, 1, 1, 1, 1, 0, 16'd0, 26'd0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_count", word_count, 0);
        check("arst_full", full, 0);
        check("arst_addr", bus.mem_wr_addr, 0);
        check("arst_en_data", {bus.mem_wr_en, bus.mem_wr_data}, 0);
        bus.in_valid = 0;
        @(negedge clk); rst_n = 1'b1;

        // randomised traffic
        for (int i = 0; i < 500; i++) begin
            logic [15:0] im;
            int op;
            op = ($urandom_range(0, 19) == 0) ? 31 : $urandom_range(0, 30);
            im = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
            step($urandom_range(0, 9) < 7, op, $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), im, 26'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        idle(1);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
